// File: rtl/life_board.sv
// life_board: toroidal game-of-life board, next generation built serially in a shadow buffer
module life_board #(
  parameter int N = 5,
  parameter int STEP_TICKS = 1000000,
  parameter int GEN_W = 16,
  parameter logic [N*N-1:0] INIT_CELLS = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             load,
  input  logic [N*N-1:0]   load_cells,
  output logic [N*N-1:0]   cells,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [GEN_W-1:0] generation
);
  localparam int NN = N * N;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int IW = NN > 1 ? $clog2(NN) : 1;
  localparam int TW = $clog2(STEP_TICKS);
  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;
  state_t           state_q;
  logic [NN-1:0]    cells_q, shadow_q;
  logic [CW-1:0]    x_q, y_q, xm, xp, ym, yp;
  logic [TW-1:0]    tick_q, tick_d;
  logic             tick, nxt, busy_q, done_q, stable_q;
  logic [GEN_W-1:0] gen_q;
  logic [3:0]       cnt;
  function automatic logic [IW-1:0] pos(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return IW'(N * int'(y) + int'(x));
  endfunction
  // neighbour count with toroidal wrap for the cell under the scan pointer, plus tick timer
  always_comb begin
    xm = x_q == '0 ? CW'(N - 1) : x_q - 1'b1;
    xp = x_q == CW'(N - 1) ? '0 : x_q + 1'b1;
    ym = y_q == '0 ? CW'(N - 1) : y_q - 1'b1;
    yp = y_q == CW'(N - 1) ? '0 : y_q + 1'b1;
    cnt = 4'(cells_q[pos(xm, ym)]) + 4'(cells_q[pos(x_q, ym)]) + 4'(cells_q[pos(xp, ym)])
        + 4'(cells_q[pos(xm, y_q)]) + 4'(cells_q[pos(xp, y_q)])
        + 4'(cells_q[pos(xm, yp)]) + 4'(cells_q[pos(x_q, yp)]) + 4'(cells_q[pos(xp, yp)]);
    nxt = cnt == 4'd3 || (cells_q[pos(x_q, y_q)] && cnt == 4'd2);
    tick = run && tick_q == TW'(STEP_TICKS - 1);
    tick_d = !run ? tick_q : tick ? '0 : tick_q + 1'b1;
  end
  // control FSM: idle until step/tick, scan every cell into the shadow, commit in one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cells_q  <= INIT_CELLS;
      shadow_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      tick_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
      gen_q    <= '0;
    end else if (load) begin
      state_q  <= IDLE;
      cells_q  <= load_cells;
      tick_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
      gen_q    <= '0;
    end else begin
      tick_q <= tick_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (step || tick) begin
          state_q <= COMPUTE;
          busy_q  <= 1'b1;
          x_q     <= '0;
          y_q     <= '0;
        end
        COMPUTE: begin
          shadow_q[pos(x_q, y_q)] <= nxt;
          x_q <= xp;
          y_q <= x_q == CW'(N - 1) ? yp : y_q;
          if (x_q == CW'(N - 1) && y_q == CW'(N - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          cells_q  <= shadow_q;
          gen_q    <= gen_q + 1'b1;
          stable_q <= shadow_q == cells_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cells      = cells_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign stable     = stable_q;
  assign generation = gen_q;
endmodule

// File: tb/tb_life_board.sv
// tb_life_board: randomized check of life_board against a 2-D game-of-life reference model
module tb_life_board;
  localparam logic [24:0] INIT = 25'h0001000;
  logic        clk = 1'b0, rst = 1'b1, run = 1'b0, step = 1'b0, load = 1'b0;
  logic [24:0] load_cells = '0, cells;
  logic        busy, done, stable;
  logic [15:0] generation;
  logic [24:0] ref_b;
  logic [15:0] ref_gen;
  int          n_chk = 0, n_fail = 0;

  life_board #(.N(5), .STEP_TICKS(4), .GEN_W(16), .INIT_CELLS(INIT)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .load(load), .load_cells(load_cells),
    .cells(cells), .busy(busy), .done(done), .stable(stable), .generation(generation)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] life_next(input logic [24:0] b);
    logic [24:0] r;
    int n;
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0) n += int'(b[5'(((y + dy + 5) % 5) * 5 + (x + dx + 5) % 5)]);
        r[5'(y * 5 + x)] = n == 3 || (b[5'(y * 5 + x)] && n == 2);
      end
    return r;
  endfunction

  task automatic do_load(input logic [24:0] v);
    load = 1'b1;
    load_cells = v;
    @(negedge clk);
    load = 1'b0;
    ref_b = v;
    ref_gen = '0;
    chk("load.cells", 32'(cells), 32'(v));
    chk("load.gen", 32'(generation), 0);
    chk("load.busy", 32'(busy), 0);
    chk("load.stable", 32'(stable), 0);
  endtask

  task automatic do_step(input string tag);
    logic [24:0] expc;
    int bc;
    bit early;
    expc = life_next(ref_b);
    bc = 0;
    early = 0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    while (busy && bc < 100) begin
      bc++;
      if (cells !== ref_b || done) early = 1;
      @(negedge clk);
    end
    chk({tag, ".busy_cycles"}, 32'(bc), 32'd26);
    chk({tag, ".early"}, 32'(early), 0);
    chk({tag, ".cells"}, 32'(cells), 32'(expc));
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".gen"}, 32'(generation), 32'(ref_gen + 16'd1));
    chk({tag, ".stable"}, 32'(stable), 32'(expc == ref_b));
    ref_gen = ref_gen + 16'd1;
    ref_b = expc;
    @(negedge clk);
    chk({tag, ".done_drop"}, 32'(done), 0);
  endtask

  initial begin
    int prev, ndone, quiet;
    logic [24:0] v;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.cells", 32'(cells), 32'(INIT));
    chk("rst.gen", 32'(generation), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.stable", 32'(stable), 0);
    ref_b = INIT;
    ref_gen = '0;
    do_step("single");
    chk("single.empty", 32'(cells), 0);

    do_load(25'h0003800);
    do_step("blink1");
    chk("blink1.vert", 32'(cells), 32'h0021080);
    do_step("blink2");
    chk("blink2.horiz", 32'(cells), 32'h0003800);

    do_load(25'h1100011);
    do_step("corner");
    chk("corner.same", 32'(cells), 32'h1100011);
    do_load(25'h0000007);
    do_step("row0");
    chk("row0.vert", 32'(cells), 32'h0200042);

    do_load('0);
    do_step("empty");

    for (int i = 0; i < 6; i++) begin
      v = 25'($urandom);
      do_load(v);
      for (int k = 0; k < 3; k++) do_step($sformatf("rnd%0d_%0d", i, k));
    end

    do_load(25'h0003800);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    load = 1'b1;
    load_cells = 25'h0000007;
    @(negedge clk);
    load = 1'b0;
    chk("abort.cells", 32'(cells), 32'h7);
    chk("abort.gen", 32'(generation), 0);
    chk("abort.busy", 32'(busy), 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 0);
    chk("abort.hold", 32'(cells), 32'h7);
    ref_b = 25'h7;
    ref_gen = '0;

    step = 1'b1;
    load = 1'b1;
    load_cells = 25'h0A5A5A5;
    @(negedge clk);
    step = 1'b0;
    load = 1'b0;
    chk("stepload.busy", 32'(busy), 0);
    chk("stepload.cells", 32'(cells), 32'h0A5A5A5);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("stepload.idle", 32'(ndone), 0);
    ref_b = 25'h0A5A5A5;
    ref_gen = '0;

    do_load(25'h0003800);
    run = 1'b1;
    prev = -1;
    ndone = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin
        chk("auto.overlap", 32'(busy), 0);
        if (prev >= 0) chk("auto.interval", 32'((c - prev) % 4), 0);
        prev = c;
        ndone++;
        ref_b = life_next(ref_b);
        ref_gen = ref_gen + 16'd1;
        chk("auto.cells", 32'(cells), 32'(ref_b));
        chk("auto.gen", 32'(generation), 32'(ref_gen));
      end
    end
    chk("auto.count", 32'(ndone >= 3), 1);
    run = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        ref_b = life_next(ref_b);
        ref_gen = ref_gen + 16'd1;
      end
    end
    quiet = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done || busy) quiet++;
    end
    chk("auto.stopped", 32'(quiet), 0);
    chk("auto.final", 32'(cells), 32'(ref_b));

    do_load(25'h0003800);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.cells", 32'(cells), 32'(INIT));
    chk("midrst.gen", 32'(generation), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.done", 32'(done), 0);
    chk("midrst.stable", 32'(stable), 0);
    ref_b = INIT;
    ref_gen = '0;
    do_step("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
